// File: rtl/zhang_cnn_quant_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the quantized
// conv accumulate/requantize datapath.
package zhang_cnn_quant_pkg;

  localparam int PROD_W  = 16;
  localparam int ACC_W   = 32;
  localparam int BIAS_W  = 32;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;

  // Saturation limits of the signed output activation
  localparam logic signed [OUT_W-1:0] OUT_MAX = 8'sh7F;
  localparam logic signed [OUT_W-1:0] OUT_MIN = 8'sh80;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    RQ  = 2'd1,
    OUT = 2'd2
  } acc_state_e;

endpackage

// File: rtl/zhang_cnn_requant_core.sv
// Combinational requantizer: bias add (no wrap), round-half-up arithmetic
// right shift, optional ReLU and saturation to the signed output range.
// Kept free of state so the pooling stage can reuse it.
module zhang_cnn_requant_core
  import zhang_cnn_quant_pkg::*;
(
  input  logic signed [ACC_W-1:0]   i_acc,
  input  logic signed [BIAS_W-1:0]  i_bias,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic                      i_relu,
  output logic signed [OUT_W-1:0]   o_data
);

  // One guard bit for the bias add, one more for the rounding offset
  localparam int RND_W = ACC_W + 2;

  logic signed [RND_W-1:0] w_sum;
  logic signed [RND_W-1:0] w_half;
  logic signed [RND_W-1:0] w_rnd;
  logic signed [RND_W-1:0] w_shifted;
  logic signed [RND_W-1:0] w_relu;

  // Widen, add bias, add the rounding half-LSB and shift arithmetically
  always_comb begin
    w_sum  = RND_W'(i_acc) + RND_W'(i_bias);
    w_half = '0;
    if (i_shift != 5'd0) begin
      w_half = RND_W'(1'b1) << (i_shift - 5'd1);
    end else begin
      w_half = '0;
    end
    w_rnd     = w_sum + w_half;
    w_shifted = w_rnd >>> i_shift;
  end

  // Clamp negatives when ReLU is on, then saturate to the output range
  always_comb begin
    w_relu = w_shifted;
    o_data = '0;
    if (i_relu && w_shifted[RND_W-1]) begin
      w_relu = '0;
    end else begin
      w_relu = w_shifted;
    end
    if (w_relu > RND_W'(OUT_MAX)) begin
      o_data = OUT_MAX;
    end else if (w_relu < RND_W'(OUT_MIN)) begin
      o_data = OUT_MIN;
    end else begin
      o_data = w_relu[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/zhang_cnn_acc_requant.sv
// Accumulates one kernel window of signed products, requantizes the sum on
// the last beat and hands one 8-bit activation downstream via valid/ready.
module zhang_cnn_acc_requant
  import zhang_cnn_quant_pkg::*;
(
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic signed [PROD_W-1:0]  prod_data,
  input  logic                      prod_last,
  input  logic                      prod_valid,
  output logic                      prod_ready,
  input  logic signed [BIAS_W-1:0]  cfg_bias,
  input  logic        [SHIFT_W-1:0] cfg_shift,
  input  logic                      cfg_relu,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [1:0]                r_rst_pipe;
  logic                      w_rst;
  acc_state_e                r_state;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [BIAS_W-1:0]  r_bias;
  logic        [SHIFT_W-1:0] r_shift;
  logic                      r_relu;
  logic signed [OUT_W-1:0]   r_out_data;
  logic                      r_out_valid;
  logic                      r_prod_ready;
  logic                      w_beat_acc;
  logic signed [OUT_W-1:0]   w_rq_data;

  // Reset asserts immediately but is released only on a clock edge
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_rst_pipe <= 2'b11;
    end else begin
      r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
  end

  assign w_rst      = r_rst_pipe[1];
  assign w_beat_acc = prod_valid & r_prod_ready;

  zhang_cnn_requant_core u_core (
    .i_acc   (r_acc),
    .i_bias  (r_bias),
    .i_shift (r_shift),
    .i_relu  (r_relu),
    .o_data  (w_rq_data)
  );

  // Window FSM: accumulate beats, requantize for one cycle, hold the result
  always_ff @(posedge ap_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state      <= ACC;
      r_acc        <= '0;
      r_bias       <= '0;
      r_shift      <= '0;
      r_relu       <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_prod_ready <= 1'b1;
    end else begin
      case (r_state)
        ACC: begin
          if (w_beat_acc) begin
            r_acc <= r_acc + ACC_W'(prod_data);
            if (prod_last) begin
              r_bias       <= cfg_bias;
              r_shift      <= cfg_shift;
              r_relu       <= cfg_relu;
              r_prod_ready <= 1'b0;
              r_state      <= RQ;
            end
          end
        end
        RQ: begin
          r_out_data  <= w_rq_data;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_prod_ready <= 1'b1;
            r_state      <= ACC;
          end
        end
        default: begin
          r_acc        <= '0;
          r_out_valid  <= 1'b0;
          r_prod_ready <= 1'b1;
          r_state      <= ACC;
        end
      endcase
    end
  end

  assign prod_ready = r_prod_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_zhang_cnn_acc_requant.sv
// Directed self-checking bench for zhang_cnn_acc_requant.
module tb_zhang_cnn_acc_requant;

  logic               ap_clk;
  logic               ap_rst;
  logic signed [15:0] prod_data;
  logic               prod_last;
  logic               prod_valid;
  logic               prod_ready;
  logic signed [31:0] cfg_bias;
  logic        [4:0]  cfg_shift;
  logic               cfg_relu;
  logic signed [7:0]  out_data;
  logic               out_valid;
  logic               out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int c_first;

  zhang_cnn_acc_requant dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .cfg_bias   (cfg_bias),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic signed [35:0] obs,
                        input logic signed [35:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a beat and hold it until accepted (bounded wait)
  task automatic send_beat(input logic signed [15:0] d, input logic l);
    int waited;
    waited = 0;
    prod_data  = d;
    prod_last  = l;
    prod_valid = 1'b1;
    while (!prod_ready && waited < 20) begin
      @(posedge ap_clk); #1;
      waited++;
    end
    chk_eq("beat_ready", prod_ready, 1'b1);
    @(posedge ap_clk); #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  // Called right after the last beat's edge; out_ready assumed high
  task automatic expect_out(input string tag, input logic signed [7:0] exp);
    chk_eq({tag, "_rq_valid"}, out_valid, 1'b0);
    @(posedge ap_clk); #1;
    chk_eq({tag, "_valid"}, out_valid, 1'b1);
    chk_eq({tag, "_data"}, out_data, exp);
    chk_eq({tag, "_rdy_low"}, prod_ready, 1'b0);
    @(posedge ap_clk); #1;
    chk_eq({tag, "_done"}, out_valid, 1'b0);
    chk_eq({tag, "_rdy_back"}, prod_ready, 1'b1);
  endtask

  task automatic set_cfg(input logic signed [31:0] b, input logic [4:0] s,
                         input logic r);
    cfg_bias  = b;
    cfg_shift = s;
    cfg_relu  = r;
  endtask

  initial begin
    ap_rst = 1'b1; prod_data = 16'sd0; prod_last = 1'b0; prod_valid = 1'b0;
    out_ready = 1'b1;
    set_cfg(32'sd0, 5'd0, 1'b0);
    #1;
    chk_eq("rst_valid", out_valid, 1'b0);
    chk_eq("rst_data", out_data, 8'sd0);
    chk_eq("rst_ready", prod_ready, 1'b1);
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;

    // 100+200-50+10 = 260, (260+2)>>2 = 65
    set_cfg(32'sd10, 5'd2, 1'b0);
    send_beat(16'sd100, 1'b0);
    send_beat(16'sd200, 1'b0);
    send_beat(-16'sd50, 1'b1);
    expect_out("basic", 8'sd65);

    // 4000 saturates high
    set_cfg(32'sd0, 5'd0, 1'b0);
    repeat (4) send_beat(16'sd1000, 1'b0);
    send_beat(16'sd0, 1'b1);
    expect_out("sat_pos", 8'sd127);

    // (-300+1)>>>1 = -150 saturates low
    set_cfg(32'sd0, 5'd1, 1'b0);
    send_beat(-16'sd300, 1'b1);
    expect_out("sat_neg", -8'sd128);

    set_cfg(32'sd0, 5'd1, 1'b1);
    send_beat(-16'sd300, 1'b1);
    expect_out("relu", 8'sd0);

    // (-3+1)>>>1 = -1
    set_cfg(32'sd0, 5'd1, 1'b0);
    send_beat(-16'sd3, 1'b1);
    expect_out("round_neg", -8'sd1);

    // (254+1)>>1 = 127 exactly, (-257+1)>>>1 = -128 exactly
    send_beat(16'sd254, 1'b1);
    expect_out("edge_max", 8'sd127);
    send_beat(-16'sd257, 1'b1);
    expect_out("edge_min", -8'sd128);

    // Bias add must not wrap: (2^31-1+1000+2^23)>>24 = 128 -> 127
    set_cfg(32'sh7FFF_FFFF, 5'd24, 1'b0);
    send_beat(16'sd1000, 1'b1);
    expect_out("no_wrap", 8'sd127);

    // Backpressure: result 30 held, next-window beat not consumed
    set_cfg(32'sd0, 5'd0, 1'b0);
    out_ready = 1'b0;
    send_beat(16'sd10, 1'b0);
    send_beat(16'sd20, 1'b1);
    @(posedge ap_clk); #1;
    prod_data = 16'sd5; prod_last = 1'b0; prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_eq("bp_valid", out_valid, 1'b1);
      chk_eq("bp_data", out_data, 8'sd30);
      chk_eq("bp_ready", prod_ready, 1'b0);
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b1;
    send_beat(16'sd5, 1'b0);
    send_beat(16'sd6, 1'b1);
    expect_out("bp_next", 8'sd11);

    // Back-to-back single-beat windows, one result every 3 cycles
    send_beat(16'sd7, 1'b1);
    @(posedge ap_clk); #1;
    chk_eq("b2b_first", out_data, 8'sd7);
    c_first = cyc;
    @(posedge ap_clk); #1;
    send_beat(16'sd9, 1'b1);
    @(posedge ap_clk); #1;
    chk_eq("b2b_second", out_data, 8'sd9);
    chk_eq("b2b_spacing", cyc - c_first, 3);
    @(posedge ap_clk); #1;

    // Reset mid-window
    send_beat(16'sd40, 1'b0);
    send_beat(16'sd41, 1'b0);
    #2 ap_rst = 1'b1;
    #1;
    chk_eq("rstw_valid", out_valid, 1'b0);
    chk_eq("rstw_ready", prod_ready, 1'b1);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;

    // Reset while holding a result
    out_ready = 1'b0;
    send_beat(16'sd3, 1'b1);
    @(posedge ap_clk); #1;
    chk_eq("rsto_pre", out_valid, 1'b1);
    #2 ap_rst = 1'b1;
    #1;
    chk_eq("rsto_valid", out_valid, 1'b0);
    chk_eq("rsto_data", out_data, 8'sd0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    out_ready = 1'b1;
    send_beat(16'sd5, 1'b1);
    expect_out("post_rst", 8'sd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
